config_chain_loader: RTL
========================

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, width of each incoming bitstream word.
REQ-002 SHALL have parameter CHAIN_LENGTH, default 32, number of static_dff cells in the downstream configuration chain.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin loading a full chain.
REQ-006 SHALL have port word_valid  input  1  word_data holds a valid bitstream word.
REQ-007 SHALL have port word_data  input  WORD_WIDTH  bitstream word, shifted out LSB first.
REQ-008 SHALL have port word_ready  output  1  loader accepts word_data this cycle.
REQ-009 SHALL have port chain_head  output  1  serial bit driving D of the first chain flip-flop.
REQ-010 SHALL have port chain_en  output  1  chain shift enable; chain captures chain_head on an edge where chain_en=1.
REQ-011 SHALL have port busy  output  1  load in progress, covering LOAD, SHIFT and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; the chain holds the complete bitstream.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-014 IDLE: start=1 -> LOAD and bit counter := CHAIN_LENGTH; start=0 -> stay in IDLE.
REQ-015 LOAD: word_ready=1; on word_valid=1, capture word_data, set shift count k = min(WORD_WIDTH, remaining), then go to SHIFT.
REQ-016 LOAD with word_valid=0: stay in LOAD; chain_en=0 and the counter holds.
REQ-017 SHIFT: for exactly k consecutive cycles, chain_en=1 and chain_head = current LSB of the captured word. On each cycle, shift the word right by one and decrement remaining.
REQ-018 End of SHIFT: if remaining=0, go to DONE; otherwise return to LOAD.
REQ-019 The first chain_en=1 cycle SHALL be the cycle immediately after the accepting edge, so handshake-to-shift latency is 1 cycle.
REQ-020 Partial final word (CHAIN_LENGTH mod WORD_WIDTH != 0): only the low `remaining` bits are shifted; upper bits are discarded and never appear on chain_head.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE. word_ready=0 and chain_en=0 in DONE.
REQ-022 chain_head SHALL be 0 whenever chain_en=0.
REQ-023 word_ready SHALL be 1 only in LOAD.
REQ-024 start while busy=1 SHALL be ignored, and no restart occurs.
REQ-025 A start asserted in the same cycle as done=1 SHALL be ignored.
REQ-026 The bit counter SHALL be $clog2(CHAIN_LENGTH+1) bits wide and never wrap below 0.
REQ-027 Total chain_en=1 cycles per load SHALL equal CHAIN_LENGTH exactly.

Reset
REQ-028 reset=1 SHALL force, asynchronously and in any state, the following values: state=IDLE, counter=0, word register=0, word_ready=0, chain_head=0, chain_en=0, busy=0, done=0.
REQ-029 Reset mid-load SHALL abandon the load with no further chain_en pulses. A new start is required after reset is released.
REQ-030 Release of reset SHALL take effect at the next rising clk edge without glitching chain_en.

Structure
REQ-031 State encodings and the counter-width function SHALL live in a shared header, config_chain_defs, for reuse by the chain testbench.
REQ-032 The word register and its shift logic SHALL be a sub-module cfg_word_serializer with ports clk, reset, load, shift, din[WORD_WIDTH] and sout. The FSM and counter stay in config_chain_loader.

Verification
REQ-033 Setup: CHAIN_LENGTH=12, WORD_WIDTH=8. Stimulus: start; words 0xA5 then 0xFF. Required response:
- chain_head over the 12 chain_en cycles = 1,0,1,0,0,1,0,1,1,1,1,1.
- Upper nibble of 0xFF is discarded.
- done pulses 1 cycle after the last chain_en.
REQ-034 Stall: word_valid held 0 for 3 cycles in LOAD -> word_ready=1 and chain_en=0 throughout; the counter is unchanged.
REQ-035 Reset asserted during the 5th SHIFT cycle -> all outputs 0 immediately (not at the next edge); state is IDLE after release.
REQ-036 start pulsed during SHIFT and again in the DONE cycle -> no second load; busy falls 1 cycle after done.
REQ-037 Default parameters, 4 words 0x01,0x02,0x04,0x08 fed back-to-back with word_valid=1 throughout -> chain_en high 32 of 36 cycles. A model of 32 static_dff cells SHALL hold the bitstream in shift order; done=1 once.

Source files
------------

// File: rtl/config_chain_defs.sv
// Shared definitions for the configuration-chain loader and its chain testbench.
//   state_e   : loader FSM state encoding
//   cnt_width : bit width of a down-counter that must hold the values 0..n inclusive
package config_chain_defs;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StShift = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Width able to hold 0..n; never below one bit so a degenerate n still elaborates.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < 1) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word register that captures a bitstream word and shifts it out LSB first.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, clears the word register
//   load   - capture din this cycle (wins over shift)
//   shift  - shift the word right by one bit this cycle
//   din    - bitstream word to capture
//   sout   - current LSB of the held word
module cfg_word_serializer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] din,
  output logic                  sout
);

  logic [WORD_WIDTH-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = din;
    end else if (shift) begin
      word_d = word_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign sout = word_q[0];

endmodule

// File: rtl/config_chain_loader.sv
// Loads a serial configuration chain of CHAIN_LENGTH flip-flops from a stream of
// WORD_WIDTH-bit words. Each accepted word is shifted out LSB first onto chain_head
// with chain_en high; a partial final word only contributes its low bits.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset; abandons any load in progress
//   start      - one-cycle request to load a full chain (honoured only when idle)
//   word_valid - word_data holds a valid word
//   word_data  - bitstream word, shifted LSB first
//   word_ready - word accepted on this cycle's edge when word_valid is also high
//   chain_head - serial data for the first chain flip-flop (0 while chain_en is low)
//   chain_en   - chain shift enable
//   busy       - a load is in progress (LOAD, SHIFT and DONE)
//   done       - one-cycle pulse once the chain holds the complete bitstream
module config_chain_loader
  import config_chain_defs::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  chain_head,
  output logic                  chain_en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = cnt_width(CHAIN_LENGTH);
  localparam int unsigned KW   = cnt_width(WORD_WIDTH);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;  // chain bits still to be shifted
  logic [KW-1:0]   k_q, k_d;      // bits left to shift from the current word
  logic            ser_load, ser_shift, ser_sout;

  cfg_word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clk  (clk),
    .reset(reset),
    .load (ser_load),
    .shift(ser_shift),
    .din  (word_data),
    .sout (ser_sout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = CntW'(CHAIN_LENGTH);
        end
      end
      StLoad: begin
        if (word_valid) begin
          ser_load = 1'b1;
          state_d  = StShift;
          // Final word may be partial: shift only what the chain still needs.
          if (32'(cnt_q) >= WORD_WIDTH) begin
            k_d = KW'(WORD_WIDTH);
          end else begin
            k_d = KW'(cnt_q);
          end
        end
      end
      StShift: begin
        ser_shift = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end
        if (k_q != '0) begin
          k_d = k_q - KW'(1);
        end
        if (k_q <= KW'(1)) begin
          state_d = (cnt_q <= CntW'(1)) ? StDone : StLoad;
        end
      end
      StDone: begin
        // start here is deliberately ignored; a new load needs a start from IDLE.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  // All outputs decode registered state only, so reset clears them immediately.
  assign word_ready = (state_q == StLoad);
  assign chain_en   = (state_q == StShift);
  assign chain_head = chain_en & ser_sout;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule
